// File: rtl/axis_extremum_scheduler_pkg.sv
// Shared types and constants for the extremum scheduler and its window datapath.
package axis_extremum_scheduler_pkg;

   typedef enum logic [1:0] {IDLE, SETTLE, ACQUIRE, STORE} state_t;

   localparam int LOG_COUNT_MAX = 20;
   localparam int CNT_W         = LOG_COUNT_MAX + 1;
   localparam int CH_IDX_W      = 3;

   function automatic logic [4:0] clamp_log_count(input logic [4:0] lc);
      return (lc > 5'(LOG_COUNT_MAX)) ? 5'(LOG_COUNT_MAX) : lc;
   endfunction

endpackage

// File: rtl/axis_extremum_scheduler_window.sv
// Signed max/min accumulator over 2^log_count beats; done marks the closing beat.
module extremum_window
   import axis_extremum_scheduler_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic                     clr,
   input  logic                     beat,
   input  logic signed [DATA_W-1:0] sample,
   input  logic [4:0]               log_count,
   output logic signed [DATA_W-1:0] max_val,
   output logic signed [DATA_W-1:0] min_val,
   output logic                     done
);

   logic [CNT_W-1:0] cnt_p0;
   logic [CNT_W-1:0] last_idx;

   assign last_idx = (CNT_W'(1) << log_count) - CNT_W'(1);
   assign done     = beat && (cnt_p0 == last_idx);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cnt_p0 <= '0;
      end else if (clr || done) begin
         cnt_p0 <= '0;
      end else if (beat) begin
         cnt_p0 <= cnt_p0 + CNT_W'(1);
      end
   end

   // First beat of a window seeds both extremes, so no reset is needed here.
   always_ff @(posedge aclk) begin
      if (beat) begin
         if (cnt_p0 == '0) begin
            max_val <= sample;
            min_val <= sample;
         end else begin
            if (sample > max_val) max_val <= sample;
            if (sample < min_val) min_val <= sample;
         end
      end
   end

endmodule

// File: rtl/axis_extremum_scheduler.sv
// Round-robin scheduler sharing one extremum window across AXI-Stream channels.
// Define AXIS_EXTREMUM_SCHEDULER_P2P_EN to add the per-channel peak-to-peak output p2p_out.
module axis_extremum_scheduler
   import axis_extremum_scheduler_pkg::*;
#(
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int CHANNEL_COUNT    = 2,
   parameter int SETTLE_CYCLES    = 4
) (
   input  logic                                       aclk,
   input  logic                                       aresetn,
   input  logic                                       enable,
   input  logic [CHANNEL_COUNT-1:0]                   channel_mask,
   input  logic [4:0]                                 log_count,
   input  logic [2:0]                                 shift,
   input  logic [CHANNEL_COUNT*AXIS_TDATA_WIDTH-1:0]  S_AXIS_tdata,
   input  logic [CHANNEL_COUNT-1:0]                   S_AXIS_tvalid,
   output logic [CHANNEL_COUNT*AXIS_TDATA_WIDTH-1:0]  max_out,
   output logic [CHANNEL_COUNT*AXIS_TDATA_WIDTH-1:0]  min_out,
`ifdef AXIS_EXTREMUM_SCHEDULER_P2P_EN
   output logic [CHANNEL_COUNT*(AXIS_TDATA_WIDTH+1)-1:0] p2p_out,
`endif
   output logic                                       result_valid,
   output logic [2:0]                                 result_channel,
   output logic                                       busy
);

   localparam int                  W           = AXIS_TDATA_WIDTH;
   localparam logic [7:0]          SETTLE_LAST = 8'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
   localparam logic [CH_IDX_W-1:0] LAST_CH     = CH_IDX_W'(CHANNEL_COUNT - 1);

   state_t              state_q, state_d;
   logic [CH_IDX_W-1:0] sel_q, ptr_q, sel_inc, base_ch, next_ch;
   logic                next_found, load;
   logic [4:0]          lc_q;
   logic [2:0]          shift_q;
   logic [7:0]          settle_q;
   logic [7:0]          mask_pad, tvalid_pad;
   logic signed [W-1:0] ch_data [8];
   logic                beat, win_clr, win_done;
   logic signed [W-1:0] win_max, win_min, max_sh, min_sh;

   assign mask_pad   = 8'(channel_mask);
   assign tvalid_pad = 8'(S_AXIS_tvalid);

   always_comb begin
      for (int i = 0; i < 8; i++) ch_data[i] = '0;
      for (int i = 0; i < CHANNEL_COUNT; i++) ch_data[i] = S_AXIS_tdata[i*W +: W];
   end

   // In STORE the search starts past the channel just finished, matching the pointer update.
   assign sel_inc = (sel_q == LAST_CH) ? '0 : sel_q + CH_IDX_W'(1);
   assign base_ch = (state_q == STORE) ? sel_inc : ptr_q;

   always_comb begin
      int idx;
      next_found = 1'b0;
      next_ch    = '0;
      idx        = 0;
      for (int k = CHANNEL_COUNT - 1; k >= 0; k--) begin
         idx = (int'(base_ch) + k) % CHANNEL_COUNT;
         if (mask_pad[CH_IDX_W'(idx)]) begin
            next_found = 1'b1;
            next_ch    = CH_IDX_W'(idx);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         IDLE:    if (enable && next_found) load = 1'b1;
         SETTLE:  if (!enable) state_d = IDLE;
                  else if (settle_q == SETTLE_LAST) state_d = ACQUIRE;
         ACQUIRE: if (!enable) state_d = IDLE;
                  else if (win_done) state_d = STORE;
         STORE:   if (enable && next_found) load = 1'b1;
                  else state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (load) state_d = (SETTLE_CYCLES == 0) ? ACQUIRE : SETTLE;
   end

   assign beat    = (state_q == ACQUIRE) && enable && tvalid_pad[sel_q];
   assign win_clr = (state_q != ACQUIRE);

   extremum_window #(.DATA_W(W)) u_window (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .clr       (win_clr),
      .beat      (beat),
      .sample    (ch_data[sel_q]),
      .log_count (lc_q),
      .max_val   (win_max),
      .min_val   (win_min),
      .done      (win_done)
   );

   assign max_sh = win_max >>> shift_q;
   assign min_sh = win_min >>> shift_q;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q        <= IDLE;
         sel_q          <= '0;
         ptr_q          <= '0;
         lc_q           <= '0;
         shift_q        <= '0;
         settle_q       <= '0;
         busy           <= 1'b0;
         result_valid   <= 1'b0;
         result_channel <= '0;
         max_out        <= '0;
         min_out        <= '0;
      end else begin
         state_q      <= state_d;
         busy         <= (state_d != IDLE);
         result_valid <= 1'b0;
         if (state_q == SETTLE) settle_q <= settle_q + 8'd1;
         if (load) begin
            sel_q    <= next_ch;
            lc_q     <= clamp_log_count(log_count);
            shift_q  <= shift;
            settle_q <= '0;
         end
         if (state_q == STORE) begin
            result_valid   <= 1'b1;
            result_channel <= sel_q;
            ptr_q          <= sel_inc;
            for (int i = 0; i < CHANNEL_COUNT; i++) begin
               if (sel_q == CH_IDX_W'(i)) begin
                  max_out[i*W +: W] <= max_sh;
                  min_out[i*W +: W] <= min_sh;
               end
            end
         end
      end
   end

`ifdef AXIS_EXTREMUM_SCHEDULER_P2P_EN
   logic signed [W:0] p2p_val;

   assign p2p_val = {win_max[W-1], win_max} - {win_min[W-1], win_min};

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         p2p_out <= '0;
      end else if (state_q == STORE) begin
         for (int i = 0; i < CHANNEL_COUNT; i++) begin
            if (sel_q == CH_IDX_W'(i)) p2p_out[i*(W+1) +: W+1] <= p2p_val;
         end
      end
   end
`endif

endmodule
